ram_fifo_ctrl: RTL and testbench

- Controller that turns the team's dual-port synchronous RAM into a first-in, first-out buffer.
- Owns the write and read pointers, generates the RAM port strobes and addresses, and tracks occupancy.
- Reports status flags and sticky error flags, and signals when RAM read data is valid.
- Sits between a producer/consumer pair and one RAM instance. The RAM's own reset input is tied low; the controller never clears memory contents.

---
 rtl/ram_fifo_ctrl.sv | 95 +++++++++
 tb/tb_ram_fifo_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: pointer, strobe and occupancy control that
// turns a dual-port synchronous RAM into a FIFO.
module ram_fifo_ctrl #(
  parameter int unsigned RAM_W    = 8,
  parameter int unsigned ADD_W    = 4,
  parameter int unsigned AF_LEVEL = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic             clr_err,
  output logic             ram_w,
  output logic             ram_r,
  output logic [ADD_W-1:0] ram_write_add,
  output logic [ADD_W-1:0] ram_read_add,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic [ADD_W:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned DEPTH = 2 ** ADD_W;
  localparam logic [ADD_W:0] AF_L = AF_LEVEL[ADD_W:0];

  // Out-of-range configurations elaborate this empty marker block.
  if (RAM_W == 0 || AF_LEVEL == 0 || AF_LEVEL > DEPTH) begin : g_bad_cfg
  end

  logic [ADD_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADD_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADD_W:0] count_q, count_d;
  logic           rd_valid_q;
  logic           ovf_q, ovf_d;
  logic           udf_q, udf_d;
  logic           push_ok, pop_ok;

  assign full = (wr_ptr_q[ADD_W] != rd_ptr_q[ADD_W]) &&
                (wr_ptr_q[ADD_W-1:0] == rd_ptr_q[ADD_W-1:0]);
  assign empty       = wr_ptr_q == rd_ptr_q;
  assign almost_full = count_q >= AF_L;

  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;

  assign ram_w         = push_ok;
  assign ram_r         = pop_ok;
  assign ram_write_add = wr_ptr_q[ADD_W-1:0];
  assign ram_read_add  = rd_ptr_q[ADD_W-1:0];
  assign rd_valid      = rd_valid_q;
  assign count         = count_q;
  assign overflow      = ovf_q;
  assign underflow     = udf_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{ADD_W{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{ADD_W{1'b0}}, pop_ok};
    count_d  = count_q + {{ADD_W{1'b0}}, push_ok}
                       - {{ADD_W{1'b0}}, pop_ok};
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    ovf_d = ovf_q | (push & full & ~flush);
    udf_d = udf_q | (pop & empty & ~flush);
    if (clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= pop_ok;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: directed stimulus with a behavioural RAM
// and a data scoreboard for ram_fifo_ctrl.
module tb_ram_fifo_ctrl;

  logic       clk;
  logic       rst_n;
  logic       push, pop, flush, clr_err;
  logic       ram_w, ram_r;
  logic [3:0] ram_write_add, ram_read_add;
  logic       rd_valid, full, empty, almost_full;
  logic [4:0] count;
  logic       overflow, underflow;

  logic [7:0] mem [16];
  logic [7:0] wdata, rdata;

  int         checks = 0;
  int         failures = 0;

  int         m_cnt, m_wa, m_ra;
  logic       m_rdv, m_ovf, m_udf;
  logic [7:0] m_rdata;
  logic [7:0] nxt;
  logic [7:0] sb [$];

  ram_fifo_ctrl #(
    .RAM_W(8), .ADD_W(4), .AF_LEVEL(12)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .push(push), .pop(pop),
    .flush(flush), .clr_err(clr_err),
    .ram_w(ram_w), .ram_r(ram_r),
    .ram_write_add(ram_write_add),
    .ram_read_add(ram_read_add),
    .rd_valid(rd_valid), .full(full),
    .empty(empty), .almost_full(almost_full),
    .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_w) mem[ram_write_add] <= wdata;
    if (ram_r) rdata <= mem[ram_read_add];
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_wa = 0; m_ra = 0;
    m_rdv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    sb.delete();
  endtask

  task automatic check_state();
    chk("wadd", 32'(ram_write_add), m_wa);
    chk("radd", 32'(ram_read_add), m_ra);
    chk("count", 32'(count), m_cnt);
    chk("full", 32'(full), 32'(m_cnt == 16));
    chk("empty", 32'(empty), 32'(m_cnt == 0));
    chk("afull", 32'(almost_full), 32'(m_cnt >= 12));
    chk("rd_valid", 32'(rd_valid), 32'(m_rdv));
    chk("ovf", 32'(overflow), 32'(m_ovf));
    chk("udf", 32'(underflow), 32'(m_udf));
  endtask

  // One cycle: drive at negedge, check, model the edge.
  task automatic cyc(input logic p, input logic po,
                     input logic f, input logic c);
    logic pok, rok, oset, uset;
    push = p; pop = po; flush = f; clr_err = c;
    wdata = nxt;
    #1;
    pok  = p && (m_cnt != 16) && !f;
    rok  = po && (m_cnt != 0) && !f;
    oset = p && (m_cnt == 16) && !f;
    uset = po && (m_cnt == 0) && !f;
    chk("ram_w", 32'(ram_w), 32'(pok));
    chk("ram_r", 32'(ram_r), 32'(rok));
    check_state();
    if (m_rdv) chk("rdata", 32'(rdata), 32'(m_rdata));
    @(posedge clk);
    m_rdv = rok;
    if (pok) begin
      sb.push_back(nxt);
      nxt++;
      m_wa = (m_wa + 1) % 16;
      m_cnt++;
    end
    if (rok) begin
      m_rdata = sb.pop_front();
      m_ra = (m_ra + 1) % 16;
      m_cnt--;
    end
    if (f) begin
      m_wa = 0; m_ra = 0; m_cnt = 0;
      sb.delete();
    end
    if (c) begin
      m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      if (oset) m_ovf = 1'b1;
      if (uset) m_udf = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    push = 1'b0; pop = 1'b0;
    flush = 1'b0; clr_err = 1'b0;
    wdata = '0; nxt = 8'h01; m_rdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_state();
    rst_n = 1'b1;
    @(negedge clk);

    // idle after reset
    repeat (5) cyc(0, 0, 0, 0);

    // fill to full, then one overflowing push
    repeat (16) cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // drain, then one underflowing pop
    repeat (16) cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);

    // steady-state streaming with wrap
    cyc(0, 0, 0, 1);
    repeat (10) cyc(1, 0, 0, 0);
    repeat (40) cyc(1, 1, 0, 0);
    repeat (6) cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);

    // flush behaviour and error clearing
    cyc(0, 0, 1, 0);
    repeat (7) cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    repeat (16) cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);

    // asynchronous reset with a read in flight
    repeat (5) cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    #1;
    chk("rdv_pre_rst", 32'(rd_valid), 32'(m_rdv));
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rdv", 32'(rd_valid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cyc(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
